// File: rtl/imem_responder.sv
// imem_responder
// Answers instruction fetches from the core with a registered 32-bit word
// and a one-cycle inst_valid strobe. Instruction data comes from a 64-bit
// backing memory over a req/ack handshake.
//
// Optional feature macro: IMEM_LINEBUF_EN
//   When defined, a one-line (8-byte) fetch buffer holds the last
//   doubleword returned by memory, so the other half can be served
//   without a new memory transaction.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   inst_addr  in  64   fetch byte address (bits [1:0] ignored)
//   inst_ena   in   1   fetch request
//   inst       out 32   fetched instruction (registered, holds when idle)
//   inst_valid out  1   one-cycle response strobe
//   mem_req    out  1   backing-memory read request (registered)
//   mem_addr   out 64   doubleword-aligned read address
//   mem_ack    in   1   memory returns data this cycle
//   mem_rdata  in  64   memory read data, valid with mem_ack
module imem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_addr,
  input  logic        inst_ena,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        mem_req_q, mem_req_d;
  logic [63:0] mem_addr_q, mem_addr_d;

  logic accept;
  logic buf_hit;
  logic [31:0] buf_word;

  // Little-endian word select within a doubleword.
  function automatic logic [31:0] sel_half(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

  // A new fetch is only taken while idle and not in the strobe cycle, which
  // guarantees inst_valid never stays high for two cycles.
  assign accept = (state_q == IDLE) && inst_ena && !inst_valid_q;

`ifdef IMEM_LINEBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;

  assign buf_hit  = buf_valid_q && (buf_tag_q == inst_addr[63:3]);
  assign buf_word = sel_half(buf_data_q, inst_addr[2]);

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    // Only a completed handshake fills the line; reset abandons it.
    if (state_q == REQ && mem_ack) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = req_addr_q[63:3];
      buf_data_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
    end
    buf_tag_q  <= buf_tag_d;
    buf_data_q <= buf_data_d;
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = 32'h0;
`endif

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_addr_d = inst_addr;
          if (buf_hit) begin
            inst_d       = buf_word;
            inst_valid_d = 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {inst_addr[63:3], 3'b000};
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        // Core-side inputs are ignored here; the transaction always
        // completes for the latched req_addr.
        if (mem_ack) begin
          inst_d       = sel_half(mem_rdata, req_addr_q[2]);
          inst_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 64'h0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
    req_addr_q <= req_addr_d;
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-side memory responder for `rvcpu`. It answers the core's fetch requests (`inst_addr`/`inst_ena`) with a 32-bit `inst` and an `inst_valid` strobe. It sources instruction data from a 64-bit backing memory through a req/ack handshake. An optional one-line (8-byte) fetch buffer serves the second instruction of each fetched doubleword without a new memory transaction.

## Interface
- No parameters; widths fixed by `defines.v` (`REG_BUS` = 64-bit).
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `inst_addr`  in  64  fetch byte address from core; bits [1:0] ignored
- `inst_ena`  in  1  fetch request from core
- `inst`  out  32  fetched instruction, registered
- `inst_valid`  out  1  one-cycle pulse: `inst` holds the response to the last accepted request
- `mem_req`  out  1  backing-memory read request, registered
- `mem_addr`  out  64  doubleword-aligned read address ({`inst_addr`[63:3], 3'b000})
- `mem_ack`  in  1  backing memory returns data this cycle
- `mem_rdata`  in  64  read data, valid when `mem_ack`=1

## Operation
- States:
  - IDLE: ready to accept a fetch.
  - REQ: `mem_req` asserted, waiting for `mem_ack`.
- Request acceptance (IDLE only): a request is accepted when `inst_ena`=1 and `inst_valid`=0.
  - `inst_ena` is ignored in REQ and in any cycle where `inst_valid`=1.
  - On acceptance, `req_addr` <= `inst_addr`.
- Hit (buffer enabled): `buf_valid`=1 and `buf_tag`==`inst_addr`[63:3].
  - Next edge: `inst` <= selected half of `buf_data`, `inst_valid` <= 1, stay IDLE.
- Miss: next edge `mem_req` <= 1, `mem_addr` <= {`inst_addr`[63:3], 3'b000}, state <= REQ.
- REQ:
  - `mem_req` and `mem_addr` are held stable until `mem_ack`.
  - On `mem_ack` edge:
    - `buf_data` <= `mem_rdata`, `buf_tag` <= `req_addr`[63:3], `buf_valid` <= 1.
    - `inst` <= selected half of `mem_rdata`; `inst_valid` <= 1.
    - `mem_req` <= 0; state <= IDLE.
- Half select uses `req_addr`[2], little-endian:
  - 0 -> bits [31:0]
  - 1 -> bits [63:32]
- `inst_ena` dropping or `inst_addr` changing during REQ does not abort the transaction. The memory handshake completes, the buffer fills, and `inst_valid` still pulses for the latched `req_addr`.
- `inst` holds its last value when `inst_valid`=0.
- `mem_ack` while in IDLE is ignored, including a stale ack after reset.
- Reset values: `inst`=32'h0, `inst_valid`=0, `mem_req`=0, `mem_addr`=64'h0, state=IDLE, `buf_valid`=0.
- Reset mid-REQ: at the reset edge, `mem_req` drops and the pending transaction is abandoned. Any data from it is never written to the buffer.

## Timing
- Hit latency: request in cycle N -> `inst_valid` in N+1. Next acceptance is possible in N+2, so sustained hit throughput is 1 instruction per 2 cycles.
- Miss latency:
  - Request in cycle N -> `mem_req` high from N+1.
  - With `mem_ack` first seen in cycle M (M>=N+1): `inst_valid` in M+1; `mem_req` low in M+1.
  - Minimum miss latency is 2 cycles (ack in N+1).
- `inst_valid` is never high for two consecutive cycles.
- Exactly one `inst_valid` pulse per accepted request.

## Configuration
- `IMEM_LINEBUF_EN` defined:
  - The fetch buffer is present and hits behave as above.
- Not defined:
  - No buffer registers are instantiated; `buf_valid` is treated as constant 0.
  - Every accepted request is a miss and goes to memory.
  - Port list and all other timing are unchanged.

## Test plan
- Reset, then idle: hold `rst`=1 for 2 cycles with `mem_ack`=1 -> `inst`=0, `inst_valid`=0, `mem_req`=0 throughout and after release.
- Cold miss:
  - Stimulus: `inst_addr`=64'h8000_0000, `inst_ena`=1; ack 3 cycles after `mem_req` with `mem_rdata`=64'h00A0_0093_0050_0113.
  - Required: `mem_addr`=64'h8000_0000; `inst`=32'h0050_0113 with `inst_valid` one cycle after ack.
- Buffer hit (`IMEM_LINEBUF_EN`):
  - Stimulus: after the cold miss, `inst_addr`=64'h8000_0004.
  - Required: `inst`=32'h00A0_0093 one cycle later, `mem_req` stays 0.
  - Without the macro: same `inst` value, but via a new `mem_req`.
- New line: `inst_addr`=64'h8000_0008 -> `mem_req`=1, `mem_addr`=64'h8000_0008, buffer retagged after ack.
- Request withdrawn during REQ: drop `inst_ena` and change `inst_addr` before ack -> `inst_valid` still pulses once with data for the original address; `mem_addr` never changes while `mem_req`=1.
- Reset mid-REQ:
  - Stimulus: assert `rst` while `mem_req`=1, then deliver `mem_ack` after release.
  - Required: `mem_req`=0 after the reset edge, no `inst_valid` pulse, and the next access to that line misses.
